// File: rtl/sdram_func_module.sv
// SDRAM controller: power-up init, then single-word write / read / refresh with auto-precharge.
// Latency: an operation's ACTIVE or REFRESH command is registered on the edge that samples the start.
// Backpressure: start requests are ignored while busy; a held start must drop to 000 before the next one.
module sdram_func_module #(
    parameter logic [13:0] T100US   = 14'd10000,
    parameter logic [11:0] MODE_VAL = 12'h030
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Init_Start_Sig,
    output logic        Init_Done_Sig,
    input  logic [2:0]  Func_Start_Sig,
    input  logic [21:0] Addr,
    input  logic [15:0] Wr_Data,
    output logic [15:0] Rd_Data,
    output logic        S_CKE,
    output logic        S_NCS,
    output logic        S_NRAS,
    output logic        S_NCAS,
    output logic        S_NWE,
    output logic [1:0]  S_BA,
    output logic [11:0] S_A,
    output logic [1:0]  S_DQM,
    inout  wire  [15:0] S_DQ
);

    // {NCS, NRAS, NCAS, NWE}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Init schedule, in cycles after the start edge. T100US is expected to be at least 1:
    // cycle 0 of init is always a NOP with CKE raised.
    localparam logic [13:0] T_PRE  = T100US;
    localparam logic [13:0] T_REF1 = T100US + 14'd3;
    localparam logic [13:0] T_REF2 = T100US + 14'd11;
    localparam logic [13:0] T_LMR  = T100US + 14'd19;
    localparam logic [13:0] T_DONE = T100US + 14'd22;

    // A10 set selects all-bank precharge / auto-precharge.
    localparam logic [11:0] A10 = 12'h400;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WRITE,
        READ,
        REFRESH,
        WAIT_LOW
    } state_t;

    state_t      state_q;
    logic [13:0] step_q;
    logic        init_cmpl_q;
    logic        cke_q;
    logic [3:0]  cmd_q;
    logic [1:0]  ba_q;
    logic [11:0] a_q;
    logic [1:0]  dqm_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;
    logic [15:0] rd_data_q;
    logic        done_q;
    logic [1:0]  ba_lat_q;
    logic [7:0]  col_lat_q;
    logic [15:0] wdat_lat_q;

    // Sequencer: step_q counts the cycle whose outputs the next edge will register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            step_q      <= 14'd0;
            init_cmpl_q <= 1'b0;
            cke_q       <= 1'b0;
            cmd_q       <= CMD_NOP;
            ba_q        <= 2'b00;
            a_q         <= 12'h000;
            dqm_q       <= 2'b11;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= 16'h0000;
            rd_data_q   <= 16'h0000;
            done_q      <= 1'b0;
            ba_lat_q    <= 2'b00;
            col_lat_q   <= 8'h00;
            wdat_lat_q  <= 16'h0000;
        end else begin
            // Everything not explicitly issued below is a NOP with the bus released.
            cmd_q   <= CMD_NOP;
            dq_oe_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Init_Start_Sig && !init_cmpl_q) begin
                        state_q <= INIT;
                        step_q  <= 14'd1;
                        cke_q   <= 1'b1;
                    end else if (init_cmpl_q && (Func_Start_Sig != 3'b000)) begin
                        step_q     <= 14'd1;
                        ba_lat_q   <= Addr[21:20];
                        col_lat_q  <= Addr[7:0];
                        wdat_lat_q <= Wr_Data;
                        if (Func_Start_Sig[2]) begin
                            state_q <= REFRESH;
                            cmd_q   <= CMD_REF;
                        end else begin
                            // Row is opened straight from the input; bank and column are replayed at c3.
                            state_q <= Func_Start_Sig[1] ? READ : WRITE;
                            cmd_q   <= CMD_ACT;
                            ba_q    <= Addr[21:20];
                            a_q     <= Addr[19:8];
                        end
                    end
                end
                INIT: begin
                    step_q <= step_q + 14'd1;
                    if (step_q == T_PRE) begin
                        cmd_q <= CMD_PRE;
                        a_q   <= A10;
                    end else if ((step_q == T_REF1) || (step_q == T_REF2)) begin
                        cmd_q <= CMD_REF;
                    end else if (step_q == T_LMR) begin
                        cmd_q <= CMD_LMR;
                        a_q   <= MODE_VAL;
                        ba_q  <= 2'b00;
                    end else if (step_q == T_DONE) begin
                        done_q      <= 1'b1;
                        dqm_q       <= 2'b00;
                        init_cmpl_q <= 1'b1;
                        state_q     <= IDLE;
                        step_q      <= 14'd0;
                    end
                end
                WRITE: begin
                    step_q <= step_q + 14'd1;
                    if (step_q == 14'd3) begin
                        cmd_q    <= CMD_WR;
                        ba_q     <= ba_lat_q;
                        a_q      <= {4'b0100, col_lat_q};
                        dq_oe_q  <= 1'b1;
                        dq_out_q <= wdat_lat_q;
                    end else if (step_q == 14'd9) begin
                        state_q <= WAIT_LOW;
                        step_q  <= 14'd0;
                    end
                end
                READ: begin
                    step_q <= step_q + 14'd1;
                    if (step_q == 14'd3) begin
                        cmd_q <= CMD_RD;
                        ba_q  <= ba_lat_q;
                        a_q   <= {4'b0100, col_lat_q};
                    end else if (step_q == 14'd7) begin
                        // CAS latency 3 after the READ in c3: the word is on the bus at the end of c6.
                        rd_data_q <= S_DQ;
                    end else if (step_q == 14'd8) begin
                        state_q <= WAIT_LOW;
                        step_q  <= 14'd0;
                    end
                end
                REFRESH: begin
                    step_q <= step_q + 14'd1;
                    if (step_q == 14'd9) begin
                        state_q <= WAIT_LOW;
                        step_q  <= 14'd0;
                    end
                end
                WAIT_LOW: begin
                    if (Func_Start_Sig == 3'b000) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    step_q  <= 14'd0;
                end
            endcase
        end
    end

    assign {S_NCS, S_NRAS, S_NCAS, S_NWE} = cmd_q;
    assign S_CKE         = cke_q;
    assign S_BA          = ba_q;
    assign S_A           = a_q;
    assign S_DQM         = dqm_q;
    assign S_DQ          = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign Rd_Data       = rd_data_q;
    assign Init_Done_Sig = done_q;

endmodule

// File: tb/tb_sdram_func_module.sv
// Directed bench for sdram_func_module with a command-event scoreboard and a CL3 read model.
// Expected SDRAM commands are queued when each operation is launched and popped as the bus shows them.
// The DQ net has a pull-up, so a released bus reads as 16'hFFFF.
module tb_sdram_func_module;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [15:0] DQ_RELEASED = 16'hFFFF;

    logic        CLK            = 1'b0;
    logic        RSTn           = 1'b0;
    logic        Init_Start_Sig = 1'b0;
    logic [2:0]  Func_Start_Sig = 3'b000;
    logic [21:0] Addr           = 22'h0;
    logic [15:0] Wr_Data        = 16'h0;
    wire         Init_Done_Sig;
    wire  [15:0] Rd_Data;
    wire         S_CKE, S_NCS, S_NRAS, S_NCAS, S_NWE;
    wire  [1:0]  S_BA;
    wire  [11:0] S_A;
    wire  [1:0]  S_DQM;
    tri1  [15:0] S_DQ;

    logic        mdl_drv = 1'b0;
    logic [15:0] mdl_val = 16'h1234;
    assign S_DQ = mdl_drv ? mdl_val : 16'hzzzz;

    sdram_func_module #(.T100US(14'd20), .MODE_VAL(12'h030)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Init_Start_Sig (Init_Start_Sig),
        .Init_Done_Sig  (Init_Done_Sig),
        .Func_Start_Sig (Func_Start_Sig),
        .Addr           (Addr),
        .Wr_Data        (Wr_Data),
        .Rd_Data        (Rd_Data),
        .S_CKE          (S_CKE),
        .S_NCS          (S_NCS),
        .S_NRAS         (S_NRAS),
        .S_NCAS         (S_NCAS),
        .S_NWE          (S_NWE),
        .S_BA           (S_BA),
        .S_A            (S_A),
        .S_DQM          (S_DQM),
        .S_DQ           (S_DQ)
    );

    typedef struct packed {
        logic [15:0] rel;
        logic [3:0]  cmd;
        logic        chk;
        logic [1:0]  ba;
        logic [11:0] a;
    } ev_t;

    ev_t exp_q[$];
    int  done_exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  n_wr = 0;
    int  wr_before = 0;

    logic [3:0] mon_cmd;
    ev_t        mon_exp;
    ev_t        mon_obs;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Next posedge is cycle 0 of the operation being launched.
    task automatic begin_op();
        start_cyc = cyc + 1;
    endtask

    task automatic push_ev(input int rel, input logic [3:0] cmd, input logic chk,
                           input logic [1:0] ba, input logic [11:0] a);
        ev_t e;
        e.rel = 16'(rel);
        e.cmd = cmd;
        e.chk = chk;
        e.ba  = chk ? ba : 2'b00;
        e.a   = chk ? a : 12'h000;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_ev(20, C_PRE, 1'b1, 2'b00, 12'h400);
        push_ev(23, C_REF, 1'b0, 2'b00, 12'h000);
        push_ev(31, C_REF, 1'b0, 2'b00, 12'h000);
        push_ev(39, C_LMR, 1'b1, 2'b00, 12'h030);
        done_exp_q.push_back(42);
    endtask

    // Bus monitor: every non-NOP command and every done pulse must match the head of its queue.
    always @(negedge CLK) begin
        if (RSTn) begin
            mon_cmd = {S_NCS, S_NRAS, S_NCAS, S_NWE};
            if (mon_cmd == C_WR) n_wr++;
            if (mon_cmd != C_NOP) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 64'(mon_cmd), 64'(C_NOP));
                end else begin
                    mon_exp     = exp_q.pop_front();
                    mon_obs.rel = 16'(cyc - start_cyc);
                    mon_obs.cmd = mon_cmd;
                    mon_obs.chk = mon_exp.chk;
                    mon_obs.ba  = mon_exp.chk ? S_BA : 2'b00;
                    mon_obs.a   = mon_exp.chk ? S_A : 12'h000;
                    check("cmd_event", 64'(mon_obs), 64'(mon_exp));
                end
            end
            if (Init_Done_Sig) begin
                if (done_exp_q.size() == 0)
                    check("unexpected_done", 64'(Init_Done_Sig), 64'd0);
                else
                    check("done_cycle", 64'(cyc - start_cyc), 64'(done_exp_q.pop_front()));
            end
        end
    end

    // CL3 memory model: returns mdl_val for the read sampled at the end of c6.
    always begin
        @(negedge CLK);
        if (RSTn && ({S_NCS, S_NRAS, S_NCAS, S_NWE} == C_RD)) begin
            repeat (3) @(posedge CLK);
            #1 mdl_drv = 1'b1;
            @(posedge CLK);
            #1 mdl_drv = 1'b0;
        end
    end

    initial begin
        // Reset values
        step(3);
        check("rst_cke",  64'(S_CKE), 64'd0);
        check("rst_cmd",  64'({S_NCS, S_NRAS, S_NCAS, S_NWE}), 64'(C_NOP));
        check("rst_ba",   64'(S_BA), 64'd0);
        check("rst_a",    64'(S_A), 64'd0);
        check("rst_dqm",  64'(S_DQM), 64'd3);
        check("rst_dq",   64'(S_DQ), 64'(DQ_RELEASED));
        check("rst_rd",   64'(Rd_Data), 64'd0);
        check("rst_done", 64'(Init_Done_Sig), 64'd0);
        RSTn = 1'b1;

        // Requests before init must be ignored
        Func_Start_Sig = 3'b001;
        step(6);
        check("pre_init_cke", 64'(S_CKE), 64'd0);
        Func_Start_Sig = 3'b000;
        step(1);

        // Init sequence
        Init_Start_Sig = 1'b1;
        begin_op();
        push_init();
        step(1);
        Init_Start_Sig = 1'b0;
        step(45);
        check("init_cke", 64'(S_CKE), 64'd1);
        check("init_dqm", 64'(S_DQM), 64'd0);
        check("init_left", 64'(exp_q.size()), 64'd0);

        // Write, inputs changed after c0 to confirm latching
        Func_Start_Sig = 3'b001;
        Addr = 22'h2ABC12;
        Wr_Data = 16'hBEEF;
        begin_op();
        push_ev(0, C_ACT, 1'b1, 2'b10, 12'hABC);
        push_ev(3, C_WR,  1'b1, 2'b10, 12'h412);
        step(2);
        Addr = 22'h0;
        Wr_Data = 16'h0;
        step(1);
        check("wr_dq_c2", 64'(S_DQ), 64'(DQ_RELEASED));
        step(1);
        check("wr_dq_c3", 64'(S_DQ), 64'h BEEF);
        step(1);
        check("wr_dq_c4", 64'(S_DQ), 64'(DQ_RELEASED));
        step(4);
        Func_Start_Sig = 3'b000;
        step(3);

        // Read with CL3 return data
        Func_Start_Sig = 3'b010;
        Addr = 22'h15A7C3;
        begin_op();
        push_ev(0, C_ACT, 1'b1, 2'b01, 12'h5A7);
        push_ev(3, C_RD,  1'b1, 2'b01, 12'h4C3);
        step(1);
        Func_Start_Sig = 3'b000;
        step(3);
        check("rd_dq_c3", 64'(S_DQ), 64'(DQ_RELEASED));
        step(3);
        check("rd_data_c6", 64'(Rd_Data), 64'd0);
        step(1);
        check("rd_data_c7", 64'(Rd_Data), 64'h1234);
        step(3);
        check("rd_data_hold", 64'(Rd_Data), 64'h1234);
        check("rd_left", 64'(exp_q.size()), 64'd0);

        // Refresh wins over read; mid-operation changes ignored
        Func_Start_Sig = 3'b110;
        begin_op();
        push_ev(0, C_REF, 1'b0, 2'b00, 12'h000);
        step(5);
        Func_Start_Sig = 3'b010;
        step(4);
        Func_Start_Sig = 3'b000;
        step(3);
        check("ref_left", 64'(exp_q.size()), 64'd0);

        // Held start: exactly one write until a 000 cycle
        Func_Start_Sig = 3'b001;
        Addr = 22'h012345;
        Wr_Data = 16'h1357;
        wr_before = n_wr;
        begin_op();
        push_ev(0, C_ACT, 1'b1, 2'b00, 12'h123);
        push_ev(3, C_WR,  1'b1, 2'b00, 12'h445);
        step(20);
        Func_Start_Sig = 3'b000;
        step(1);
        check("held_write_count", 64'(n_wr - wr_before), 64'd1);
        Func_Start_Sig = 3'b001;
        Addr = 22'h3FFF00;
        begin_op();
        push_ev(0, C_ACT, 1'b1, 2'b11, 12'hFFF);
        push_ev(3, C_WR,  1'b1, 2'b11, 12'h400);
        step(1);
        Func_Start_Sig = 3'b000;
        step(12);
        check("held_left", 64'(exp_q.size()), 64'd0);

        // Reset in c2 of a write
        Func_Start_Sig = 3'b001;
        Addr = 22'h2ABC12;
        Wr_Data = 16'hBEEF;
        begin_op();
        push_ev(0, C_ACT, 1'b1, 2'b10, 12'hABC);
        step(3);
        RSTn = 1'b0;
        #1;
        check("mid_rst_ctl", 64'({S_CKE, S_NCS, S_NRAS, S_NCAS, S_NWE, S_DQM, Init_Done_Sig}),
              64'({1'b0, C_NOP, 2'b11, 1'b0}));
        check("mid_rst_addr", 64'({S_BA, S_A}), 64'd0);
        check("mid_rst_dq", 64'(S_DQ), 64'(DQ_RELEASED));
        check("mid_rst_rd", 64'(Rd_Data), 64'd0);
        step(2);
        RSTn = 1'b1;
        step(12);
        check("post_rst_cke", 64'(S_CKE), 64'd0);
        check("post_rst_left", 64'(exp_q.size()), 64'd0);
        Func_Start_Sig = 3'b000;
        step(1);

        // Re-init with the start held high: must run once only
        Init_Start_Sig = 1'b1;
        begin_op();
        push_init();
        step(46);
        check("reinit_cke", 64'(S_CKE), 64'd1);
        step(30);
        check("reinit_left", 64'(exp_q.size()), 64'd0);

        // Operations work again after re-init
        Func_Start_Sig = 3'b001;
        Addr = 22'h1000FF;
        Wr_Data = 16'hA5A5;
        begin_op();
        push_ev(0, C_ACT, 1'b1, 2'b01, 12'h000);
        push_ev(3, C_WR,  1'b1, 2'b01, 12'h4FF);
        step(1);
        Func_Start_Sig = 3'b000;
        step(3);
        check("final_wr_dq_c3", 64'(S_DQ), 64'hA5A5);
        step(8);
        Init_Start_Sig = 1'b0;
        check("final_left", 64'(exp_q.size()), 64'd0);
        check("done_left", 64'(done_exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
